// File: rtl/fetch_pkg.sv
// Shared defaults and the fetch-entry type for the instruction fetch stage.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 8;
  localparam int FETCH_DATA_W = 8;
  localparam int FETCH_DEPTH  = 4;
  localparam logic [FETCH_ADDR_W-1:0] FETCH_RESET_PC = 8'h00;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] addr;
    logic [FETCH_DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: DEPTH entries, wrap-around pointers, synchronous clear,
// asynchronous active-high reset. Head is readable combinationally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = FETCH_DEPTH,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  entry_t           i_wdata,
  output entry_t           o_rdata,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // NOTE: state registers use non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (i_push && !i_pop)      r_count <= r_count + CNT_W'(1);
      else if (!i_push && i_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // NOTE: storage is reset because the head drives instr/instr_pc directly
  // and those must read zero out of reset; a larger array would skip this.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(i_push && !i_pop && !i_clear && o_full));
  a_no_underflow : assert property (@(posedge clk) disable iff (rst)
    !(i_pop && o_empty));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-based issue to a 1-cycle memory, epoch-tagged
// returns into a prefetch FIFO, redirect flush. FETCH_BYPASS_EN enables empty-FIFO bypass.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                DATA_W   = FETCH_DATA_W,
  parameter int                DEPTH    = FETCH_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC),
  localparam int               CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [CNT_W-1:0]  fifo_count
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_inflight_addr;
  logic              r_inflight;
  logic              r_inflight_epoch;
  logic              r_epoch;

  entry_t            w_head;
  entry_t            w_resp;
  logic              w_resp_hit;
  logic              w_bypass;
  logic              w_pop;
  logic              w_fifo_push;
  logic              w_fifo_pop;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [CNT_W:0]    w_credit_used;

  // A return is kept only if no redirect has happened since it was issued.
  assign w_resp_hit = r_inflight && (r_inflight_epoch == r_epoch);
  assign w_resp     = '{addr: r_inflight_addr, data: mem_rdata};

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_resp_hit && w_fifo_empty;
`else
  assign w_bypass = 1'b0;
`endif

  assign instr_valid = !w_fifo_empty || w_bypass;
  assign instr       = w_bypass ? mem_rdata       : w_head.data;
  assign instr_pc    = w_bypass ? r_inflight_addr : w_head.addr;

  assign w_pop       = instr_valid && instr_ready;
  assign w_fifo_pop  = w_pop && !w_fifo_empty;
  assign w_fifo_push = w_resp_hit && !redirect_valid && !(w_bypass && instr_ready);

  // Buffered + in-flight bytes after this cycle's pop must leave room for one more.
  assign w_credit_used = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(r_inflight)
                       - (CNT_W+1)'(w_pop);
  assign mem_req  = !rst && !redirect_valid && (w_credit_used < (CNT_W+1)'(DEPTH));
  assign mem_addr = r_fetch_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc       <= RESET_PC;
      r_inflight       <= 1'b0;
      r_inflight_addr  <= '0;
      r_inflight_epoch <= 1'b0;
      r_epoch          <= 1'b0;
    end else begin
      r_inflight <= mem_req;
      if (mem_req) begin
        r_inflight_addr  <= r_fetch_pc;
        r_inflight_epoch <= r_epoch;
      end
      if (redirect_valid) begin
        r_fetch_pc <= redirect_addr;
        r_epoch    <= ~r_epoch;
      end else if (mem_req) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_fifo_push),
    .i_pop   (w_fifo_pop),
    .i_clear (redirect_valid),
    .i_wdata (w_resp),
    .o_rdata (w_head),
    .o_count (fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  a_credit_holds : assert property (@(posedge clk) disable iff (rst)
    !(w_fifo_push && w_fifo_full && !w_fifo_pop));
  a_count_bounded : assert property (@(posedge clk) disable iff (rst)
    fifo_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed latency/credit/redirect/reset
// vectors plus a randomized scoreboard run against a memory image model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = 8'hEE;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_addr = '0;
  logic [CNT_W-1:0]  fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .RESET_PC (8'h00)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .fifo_count     (fifo_count)
  );

  function automatic logic [7:0] image(input logic [7:0] a);
    return (a ^ 8'h5A) + 8'h11;
  endfunction

  // Synchronous-read memory: request seen in cycle N, data driven in cycle N+1.
  logic       mem_pend = 1'b0;
  logic [7:0] mem_pend_addr = '0;
  always @(negedge clk) begin
    mem_pend      = mem_req;
    mem_pend_addr = mem_addr;
  end
  always @(posedge clk) begin
    #1;
    mem_rdata = mem_pend ? image(mem_pend_addr) : 8'hEE;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic ready);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    instr_ready    = ready;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Free-running stream from RESET_PC with instr_ready held high.
  task automatic check_stream(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      if (k > 0) next_cycle();
      mid();
      check({tag, "_req"},   32'(mem_req),     32'd1);
      check({tag, "_addr"},  32'(mem_addr),    32'(k));
      check({tag, "_valid"}, 32'(instr_valid), 32'(k >= LAT));
      if (k >= LAT) begin
        check({tag, "_pc"},    32'(instr_pc), 32'(k - LAT));
        check({tag, "_instr"}, 32'(instr),    32'(image(8'(k - LAT))));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp4 [4];
    logic [7:0] exp_pc;
    int         n_acc;

    // Reset state
    repeat (2) @(posedge clk);
    mid();
    check("rst_req",   32'(mem_req),     32'd0);
    check("rst_addr",  32'(mem_addr),    32'h00);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", 32'(instr),       32'd0);
    check("rst_pc",    32'(instr_pc),    32'd0);
    check("rst_count", 32'(fifo_count),  32'd0);

    // 1: streaming after reset release
    do_reset(1'b1);
    check_stream("t1", 8);

    // 2: back-pressure fills exactly DEPTH credits, then drains in order
    do_reset(1'b0);
    for (int k = 0; k < 7; k++) begin
      if (k > 0) next_cycle();
      mid();
      check("t2_req", 32'(mem_req), 32'(k < 4));
      if (k < 4) check("t2_addr", 32'(mem_addr), 32'(k));
      if (k >= 5) check("t2_count", 32'(fifo_count), 32'd4);
    end
    check("t2_full_pc", 32'(instr_pc), 32'h00);
    next_cycle();
    instr_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (j > 0) next_cycle();
      mid();
      check("t2_dr_req",   32'(mem_req),  32'd1);
      check("t2_dr_addr",  32'(mem_addr), 32'(4 + j));
      check("t2_dr_pc",    32'(instr_pc), 32'(j));
      check("t2_dr_instr", 32'(instr),    32'(image(8'(j))));
    end

    // 3: redirect with 2 buffered + 1 in flight
    do_reset(1'b0);
    repeat (3) next_cycle();
    redirect_valid = 1'b1;
    redirect_addr  = 8'h40;
    mid();
    check("t3_pre_count", 32'(fifo_count), 32'd2);
    check("t3_T_req",     32'(mem_req),    32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    mid();
    check("t3_T1_count", 32'(fifo_count),  32'd0);
    check("t3_T1_valid", 32'(instr_valid), 32'd0);
    check("t3_T1_addr",  32'(mem_addr),    32'h40);
    check("t3_T1_req",   32'(mem_req),     32'd1);
    next_cycle();
    mid();
    check("t3_T2_valid", 32'(instr_valid), 32'(LAT == 1));
    check("t3_T2_addr",  32'(mem_addr),    32'h41);
    if (LAT == 1) check("t3_T2_pc", 32'(instr_pc), 32'h40);
    next_cycle();
    mid();
    check("t3_T3_valid", 32'(instr_valid), 32'd1);
    check("t3_T3_pc",    32'(instr_pc),    32'h40);
    check("t3_T3_instr", 32'(instr),       32'(image(8'h40)));
    check("t3_T3_count", 32'(fifo_count),  32'd1);
    next_cycle();
    instr_ready = 1'b1;
    next_cycle();
    mid();
    check("t3_next_pc", 32'(instr_pc), 32'h41);

    // 4: redirect near the top of the address space wraps
    do_reset(1'b1);
    repeat (3) next_cycle();
    redirect_valid = 1'b1;
    redirect_addr  = 8'hFE;
    next_cycle();
    redirect_valid = 1'b0;
    q = {};
    for (int k = 0; k < 8; k++) begin
      if (k > 0) next_cycle();
      mid();
      if (instr_valid && instr_ready) begin
        q.push_back(instr_pc);
        check("t4_instr", 32'(instr), 32'(image(instr_pc)));
      end
    end
    exp4 = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    check("t4_n", 32'(q.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < q.size()) check("t4_pc", 32'(q[i]), 32'(exp4[i]));
    end

    // 5: asynchronous reset mid-stream
    do_reset(1'b1);
    next_cycle();
    redirect_valid = 1'b1;
    redirect_addr  = 8'h80;
    next_cycle();
    redirect_valid = 1'b0;
    repeat (3) next_cycle();
    mid();
    check("t5_pre_valid", 32'(instr_valid), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("t5_async_valid", 32'(instr_valid), 32'd0);
    check("t5_async_req",   32'(mem_req),     32'd0);
    check("t5_async_count", 32'(fifo_count),  32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    check_stream("t5", 6);

    // 6: random back-pressure and redirects against a scoreboard
    do_reset(1'b0);
    exp_pc = 8'h00;
    n_acc  = 0;
    for (int c = 0; c < 10000; c++) begin
      next_cycle();
      instr_ready    = ($urandom_range(0, 99) < 60);
      redirect_valid = ($urandom_range(0, 99) < 3);
      redirect_addr  = 8'($urandom());
      mid();
      if (instr_valid && instr_ready) begin
        n_acc++;
        check("t6_pc",    32'(instr_pc), 32'(exp_pc));
        check("t6_instr", 32'(instr),    32'(image(instr_pc)));
        exp_pc = instr_pc + 8'h01;
      end
      if (redirect_valid) exp_pc = redirect_addr;
      check("t6_bound", 32'(fifo_count <= 3'(DEPTH)), 32'd1);
    end
    redirect_valid = 1'b0;
    check("t6_progress", 32'(n_acc > 1000), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
